// File: rtl/mod_updown_counter.sv
// Up/down modulus counter with parallel load, prescaler, one-shot halt,
// a terminal-count pulse and a combinational compare against the registered count.
module mod_updown_counter #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [N-1:0]          load_val,
    input  logic [N-1:0]          modulus,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  one_shot,
    input  logic [N-1:0]          cmp,
    output logic [N-1:0]          count,
    output logic                  tc,
    output logic                  cmp_out,
    output logic                  done
);

    localparam logic [N-1:0]          CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] psc;
    logic                  tick;
    logic                  at_term;

    assign tick = en && (psc == prescale);

    // Up terminates at or above modulus, so a loaded out-of-range value never
    // climbs towards 2^N; down always walks back into range before terminating.
    assign at_term = up ? (count >= modulus) : (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            psc   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            psc   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (en) begin
                psc <= tick ? '0 : psc + PSC_ONE;
            end
            // A finished one-shot keeps its value until the next load or reset.
            if (tick && !done) begin
                if (at_term) begin
                    tc <= 1'b1;
                    if (one_shot) begin
                        done <= 1'b1;
                    end else begin
                        count <= up ? '0 : modulus;
                    end
                end else begin
                    count <= up ? count + CNT_ONE : count - CNT_ONE;
                end
            end
        end
    end

    assign cmp_out = (count < cmp);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: directed scenarios plus a
// randomized run, all checked against a behavioural model of the counter.
module tb_mod_updown_counter;

    localparam int N  = 8;
    localparam int PW = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic          up;
    logic          load;
    logic [N-1:0]  load_val;
    logic [N-1:0]  modulus;
    logic [PW-1:0] prescale;
    logic          one_shot;
    logic [N-1:0]  cmp;
    logic [N-1:0]  count;
    logic          tc;
    logic          cmp_out;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference state, plain integers
    int m_count = 0;
    int m_psc   = 0;
    int m_tc    = 0;
    int m_done  = 0;

    mod_updown_counter #(.N(N), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .modulus  (modulus),
        .prescale (prescale),
        .one_shot (one_shot),
        .cmp      (cmp),
        .count    (count),
        .tc       (tc),
        .cmp_out  (cmp_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance model from the current inputs, then one clock; sample 1ns after the edge.
    task automatic step();
        int tick;
        if (reset) begin
            m_count = 0; m_psc = 0; m_tc = 0; m_done = 0;
        end else if (load) begin
            m_count = int'(load_val); m_psc = 0; m_tc = 0; m_done = 0;
        end else begin
            tick = 0;
            m_tc = 0;
            if (en) begin
                if (m_psc == int'(prescale)) begin
                    m_psc = 0;
                    tick  = 1;
                end else begin
                    m_psc = (m_psc + 1) % (1 << PW);
                end
            end
            if (tick == 1 && m_done == 0) begin
                if (up && m_count >= int'(modulus)) begin
                    m_tc = 1;
                    if (one_shot) m_done = 1;
                    else m_count = 0;
                end else if (!up && m_count == 0) begin
                    m_tc = 1;
                    if (one_shot) m_done = 1;
                    else m_count = int'(modulus);
                end else if (up) begin
                    m_count = m_count + 1;
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        modulus = 8'd4; prescale = '0; one_shot = 1'b0; cmp = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; load = 1'b1; load_val = 8'd77; cmp = 8'd3;
        step();
        step();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0 || cmp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset: count=%0d tc=%b done=%b cmp_out=%b, want 0 0 0 1", count, tc, done, cmp_out);
        end
        reset = 1'b0; load = 1'b0;
    endtask

    task automatic test_up_wrap();
        int exp_seq [11] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
        en = 1'b1; up = 1'b1; modulus = 8'd4; prescale = '0; one_shot = 1'b0; cmp = 8'd2;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (count !== exp_seq[i][N-1:0] || tc !== (exp_seq[i] == 0 && i > 0) ||
                done !== 1'b0 || cmp_out !== (exp_seq[i] < 2)) begin
                errors++;
                $display("FAIL up_wrap i=%0d: count=%0d tc=%b done=%b cmp_out=%b, want count=%0d",
                         i, count, tc, done, cmp_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_down_prescale();
        int tc_seen = 0;
        int frozen;
        load = 1'b1; load_val = 8'd3; modulus = 8'd3; prescale = 4'd2; up = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            en = (i >= 5 && i < 10) ? 1'b0 : 1'b1;
            frozen = int'(count);
            step();
            if (tc === 1'b1) tc_seen++;
            checks++;
            if (count !== m_count[N-1:0] || tc !== m_tc[0] || done !== m_done[0] ||
                (!en && int'(count) != frozen)) begin
                errors++;
                $display("FAIL down_prescale i=%0d: count=%0d tc=%b done=%b, want count=%0d tc=%0d done=%0d",
                         i, count, tc, done, m_count, m_tc, m_done);
            end
        end
        // 12 enabled clocks at a 3-clock tick: 3->2->1->0->3, one terminal pulse
        checks++;
        if (tc_seen != 1 || count !== 8'd3) begin
            errors++;
            $display("FAIL down_prescale_tc: pulses=%0d count=%0d, want 1 and 3", tc_seen, count);
        end
    endtask

    task automatic test_one_shot();
        load = 1'b1; load_val = 8'd0; modulus = 8'd5; prescale = '0; up = 1'b1; one_shot = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 26; i++) begin
            step();
            checks++;
            if (count !== m_count[N-1:0] || tc !== m_tc[0] || done !== m_done[0] ||
                (i >= 5 && count !== 8'd5) || (i == 5 && (tc !== 1'b1 || done !== 1'b1)) ||
                (i > 5 && tc !== 1'b0)) begin
                errors++;
                $display("FAIL one_shot i=%0d: count=%0d tc=%b done=%b, want count=%0d tc=%0d done=%0d",
                         i, count, tc, done, m_count, m_tc, m_done);
            end
        end
        load = 1'b1; load_val = 8'd2;
        step();
        load = 1'b0;
        step();
        checks++;
        if (count !== 8'd3 || done !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_reload: count=%0d done=%b tc=%b, want 3 0 0", count, done, tc);
        end
        one_shot = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 8'd7; modulus = 8'd7; up = 1'b1; en = 1'b1; prescale = '0;
        step();
        load_val = 8'd9;
        step();
        checks++;
        if (count !== 8'd9 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: count=%0d tc=%b, want 9 0", count, tc);
        end
        load = 1'b0;
        step();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL load_over_mod_term: count=%0d tc=%b, want 0 1", count, tc);
        end
        step(); step();
        reset = 1'b1; load = 1'b1; cmp = 8'd0;
        step();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0 || cmp_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: count=%0d tc=%b done=%b cmp_out=%b, want 0 0 0 0", count, tc, done, cmp_out);
        end
        reset = 1'b0; load = 1'b0;
    endtask

    task automatic test_mod_zero();
        modulus = 8'd0; prescale = '0; one_shot = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (count !== 8'd0 || tc !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL mod_zero i=%0d: count=%0d tc=%b done=%b, want 0 1 0", i, count, tc, done);
            end
        end
        one_shot = 1'b1;
        step();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL mod_zero_oneshot: count=%0d tc=%b done=%b, want 0 1 1", count, tc, done);
        end
        step();
        checks++;
        if (tc !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL mod_zero_held: tc=%b done=%b, want 0 1", tc, done);
        end
        one_shot = 1'b0;
    endtask

    task automatic test_cmp_sweep();
        int cmp_vals [3] = '{0, 4, 10};
        int ones;
        modulus = 8'd9; up = 1'b1; en = 1'b1; prescale = '0; one_shot = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load = 1'b1; load_val = 8'd0; cmp = cmp_vals[k][N-1:0];
            step();
            load = 1'b0;
            ones = 0;
            for (int i = 0; i < 10; i++) begin
                if (cmp_out === 1'b1) ones++;
                checks++;
                if (cmp_out !== (m_count < cmp_vals[k]) || count !== m_count[N-1:0]) begin
                    errors++;
                    $display("FAIL cmp_cycle cmp=%0d: count=%0d cmp_out=%b, want count=%0d", cmp_vals[k], count, cmp_out, m_count);
                end
                step();
            end
            checks++;
            if (ones != ((cmp_vals[k] > 10) ? 10 : cmp_vals[k])) begin
                errors++;
                $display("FAIL cmp_sweep cmp=%0d: high cycles=%0d of 10", cmp_vals[k], ones);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = $urandom_range(0, 20);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) modulus = $urandom_range(0, 12);
            if ($urandom_range(0, 15) == 0) prescale = $urandom_range(0, 3);
            if ($urandom_range(0, 31) == 0) one_shot = $urandom_range(0, 1);
            cmp = $urandom_range(0, 15);
            step();
            checks++;
            if (count !== m_count[N-1:0] || tc !== m_tc[0] || done !== m_done[0] ||
                cmp_out !== (m_count < int'(cmp))) begin
                errors++;
                $display("FAIL random i=%0d: count=%0d tc=%b done=%b cmp_out=%b, want count=%0d tc=%0d done=%0d",
                         i, count, tc, done, cmp_out, m_count, m_tc, m_done);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_up_wrap();
        test_down_prescale();
        test_one_shot();
        test_load_priority();
        test_mod_zero();
        test_cmp_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's basic enable counter. Adds modulus wrap, up/down direction, a synchronous parallel load, a programmable prescaler, a one-shot mode with a done flag, a terminal-count pulse and a compare output. It is the timebase and duty-compare core for the PWM and timer blocks, and replaces the plain free-running counter in those designs.

Parameters:
N, 8, counter width in bits; count range is 0..modulus.
PRESCALE_W, 4, width of the prescale field; a tick occurs every (prescale+1) enabled clocks.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; gates the prescaler and therefore all ticks.
up  input  1  direction: 1 = up, 0 = down; sampled on every tick.
load  input  1  synchronous parallel load strobe.
load_val  input  N  value loaded into count when load=1.
modulus  input  N  terminal value; up counts 0..modulus, down counts modulus..0.
prescale  input  PRESCALE_W  tick divider; 0 means a tick every enabled clock.
one_shot  input  1  1 = halt at the terminal event; 0 = wrap continuously.
cmp  input  N  compare threshold.
count  output  N  current counter value (registered).
tc  output  1  terminal-count pulse (registered, one cycle wide).
cmp_out  output  1  combinational (count < cmp), driven from the registered count.
done  output  1  one-shot completed flag (registered, sticky).

Behaviour:
- Reset, synchronous and active-high; one clock and one reset only.
  - On reset: count=0, prescaler=0, tc=0, done=0. cmp_out follows as (0 < cmp).
- Priority each cycle: reset > load > tick > hold.
- Prescaler (internal PRESCALE_W-bit psc):
  - en=1: if psc==prescale then psc<=0 and tick=1; else psc<=psc+1.
  - en=0: psc holds; no tick.
  - load=1: psc<=0.
  - If prescale is changed to a value below the current psc, psc counts up, wraps through 2^PRESCALE_W and ticks on the next equality (no special handling).
- Load:
  - count<=load_val, done<=0, tc<=0. A load value above modulus is legal.
- Tick, with done=0:
  - up=1, count>=modulus: terminal event.
  - up=1, otherwise: count<=count+1.
  - up=0, count==0: terminal event.
  - up=0, otherwise: count<=count-1. This applies even when count>modulus; the counter decrements down into range.
- Terminal event, one_shot=0:
  - Up: count<=0. Down: count<=modulus.
  - tc<=1 for exactly one cycle, aligned with the updated count.
- Terminal event, one_shot=1:
  - count holds: modulus for up (or the out-of-range value if count>modulus), 0 for down.
  - tc<=1 for one cycle; done<=1.
- Done handling:
  - While done=1, ticks are ignored and count holds regardless of one_shot, up or en.
  - done clears only on load or reset.
- tc is 0 in every cycle without a terminal event.
- Latency: one clock from the tick-qualifying edge to the count/tc update. cmp_out has zero added latency relative to count.
- modulus=0:
  - count stays 0 and every tick is a terminal event, so tc pulses on every tick.
  - With one_shot=1, the first tick sets done.
- Direction change mid-count: takes effect on the next tick, with no extra tc.
- Inputs modulus, cmp and prescale may change at any time; the new values are used from the next edge.
- Arithmetic is unsigned N-bit. No internal wrap past 2^N-1 can occur, because up always terminates at count>=modulus.

Test Plan:
1. Reset, then N=8, prescale=0, modulus=4, up=1, en=1, one_shot=0 for 12 clocks -> count 0,1,2,3,4,0,1,2,3,4,0,1. tc=1 in the cycles showing count=0 after 4 only; done stays 0.
2. prescale=2, modulus=3, up=0, after load_val=3 -> count decrements once every 3 clocks: 3,2,1,0,3. tc pulses once, for one cycle, at 0->3. Drop en for 5 clocks mid-run -> count and psc frozen; counting resumes with the same phase.
3. one_shot=1, up=1, modulus=5, from load 0 -> count reaches 5; next tick gives tc=1 for one cycle and done=1. Count holds at 5 for 20 further clocks. Then load=1 with load_val=2 -> count=2, done=0, counting resumes.
4. Simultaneous load=1, tick and terminal condition (count=modulus=7, up=1) -> count=load_val (e.g. 9), tc=0. Next tick with up=1 -> terminal event (9>=7): count=0, tc=1. Reset asserted mid-run with load=1 -> all outputs return to reset values.
5. modulus=0, prescale=0, one_shot=0 -> count constant 0 and tc=1 every clock. Then set one_shot=1 -> done=1 after the first tick.
6. cmp sweep with modulus=9, up counting: cmp=0 -> cmp_out always 0; cmp=4 -> cmp_out=1 for counts 0..3 (4 of 10 cycles); cmp=10 -> cmp_out always 1. cmp_out changes in the same cycle as count.
